spi_shift_engine: RTL and testbench

- Bit-level SPI master shift engine. It sits directly downstream of the APB SPI register block.
- Consumes that block's go, cpol, cpha, clk_divider and datai fields. Produces datao, busy and done.
- Drives the SCLK/MOSI pads and samples the MISO pad.
- Full-duplex transfer of one DATA_WIDTH word per start; supports all four CPOL/CPHA modes.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_clk_divider.sv | 29 ++
 rtl/spi_shift_engine.sv | 133 +++++++++++++
 tb/tb_spi_shift_engine.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master shift engine.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } spi_state_t;

  // SPI modes encoded as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DATA_WIDTH_DEF        = 8;
  localparam int CLK_DIVIDER_WIDTH_DEF = 8;

endpackage

// File: rtl/spi_clk_divider.sv
// Half-period tick generator: counts 0..divider and pulses tick on the last count.
module spi_clk_divider
  import spi_pkg::*;
#(
  parameter int CLK_DIVIDER_WIDTH = CLK_DIVIDER_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [CLK_DIVIDER_WIDTH-1:0] divider,
  output logic                         tick
);

  logic [CLK_DIVIDER_WIDTH-1:0] count_reg;

  // Wraps at divider, so an all-ones divider still fits the counter width
  assign tick = (count_reg == divider);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: one full-duplex DATA_WIDTH word per go rising edge,
// all four CPOL/CPHA modes, SCLK half-period of clk_divider+1 clk cycles.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int CLK_DIVIDER_WIDTH = CLK_DIVIDER_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         CPOL,
  input  logic                         CPHA,
  input  logic [CLK_DIVIDER_WIDTH-1:0] clk_divider,
  input  logic                         go,
  input  logic [DATA_WIDTH-1:0]        datai,
  output logic [DATA_WIDTH-1:0]        datao,
  output logic                         busy,
  output logic                         done,
  input  logic                         miso,
  output logic                         mosi,
  output logic                         sclk
);

  localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

  spi_state_t                   state_reg, state_next;
  logic                         go_q_reg;
  logic [1:0]                   mode_reg;
  logic [CLK_DIVIDER_WIDTH-1:0] div_reg;
  logic [DATA_WIDTH-1:0]        tx_reg, rx_reg, datao_reg;
  logic [EDGE_W-1:0]            edge_cnt_reg;
  logic                         sclk_reg;

  logic                  start, tick, xfer_tick, leading, sample_edge;
  logic                  sample_en, shift_en, last_edge;
  logic [DATA_WIDTH-1:0] rx_shifted;

  spi_clk_divider #(
    .CLK_DIVIDER_WIDTH(CLK_DIVIDER_WIDTH)
  ) u_clk_divider (
    .clk    (clk),
    .reset  (reset),
    .clear  (start),
    .divider(div_reg),
    .tick   (tick)
  );

  assign start     = go & ~go_q_reg & (state_reg == IDLE);
  assign xfer_tick = (state_reg == XFER) & tick;
  // edge_cnt_reg holds edges already made, so an even count means the coming edge is leading
  assign leading   = ~edge_cnt_reg[0];

  always_comb begin
    sample_edge = leading;
    case (mode_reg)
      MODE0, MODE2: sample_edge = leading;
      MODE1, MODE3: sample_edge = ~leading;
      default:      sample_edge = leading;
    endcase
  end

  // CPHA=1 skips the shift on edge 1: the MSB has been on mosi since SETUP
  assign sample_en  = xfer_tick & sample_edge;
  assign shift_en   = xfer_tick & ~sample_edge & (edge_cnt_reg != '0);
  assign last_edge  = xfer_tick & (edge_cnt_reg == LAST_EDGE);
  assign rx_shifted = {rx_reg[DATA_WIDTH-2:0], miso};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   if (tick) state_next = XFER;
      XFER:    if (last_edge) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_q_reg     <= 1'b0;
      mode_reg     <= MODE0;
      div_reg      <= '0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      datao_reg    <= '0;
      edge_cnt_reg <= '0;
      sclk_reg     <= 1'b0;
    end else begin
      go_q_reg <= go;
      if (start) begin
        mode_reg     <= {CPOL, CPHA};
        div_reg      <= clk_divider;
        tx_reg       <= datai;
        rx_reg       <= '0;
        edge_cnt_reg <= '0;
      end else if (xfer_tick) begin
        edge_cnt_reg <= edge_cnt_reg + 1'b1;
      end
      if (state_reg == IDLE) begin
        sclk_reg <= CPOL;
      end else if (xfer_tick) begin
        sclk_reg <= ~sclk_reg;
      end
      if (sample_en) begin
        rx_reg <= rx_shifted;
      end
      if (shift_en) begin
        tx_reg <= {tx_reg[DATA_WIDTH-2:0], 1'b0};
      end
      // The final edge may also be a sample edge; fold that bit in directly
      if (last_edge) begin
        datao_reg <= sample_en ? rx_shifted : rx_reg;
      end
    end
  end

  assign sclk  = sclk_reg;
  assign mosi  = (state_reg != IDLE) & tx_reg[DATA_WIDTH-1];
  assign busy  = (state_reg != IDLE);
  assign done  = (state_reg == DONE);
  assign datao = datao_reg;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: directed mode/timing scenarios plus
// randomized transfers against a bit-serial SPI slave and timing model.
module tb_spi_shift_engine;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          CPOL, CPHA, go, miso;
  logic [CW-1:0] clk_divider;
  logic [DW-1:0] datai, datao;
  logic          busy, done, mosi, sclk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_shift_engine #(
    .DATA_WIDTH(DW),
    .CLK_DIVIDER_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .CPOL       (CPOL),
    .CPHA       (CPHA),
    .clk_divider(clk_divider),
    .go         (go),
    .datai      (datai),
    .datao      (datao),
    .busy       (busy),
    .done       (done),
    .miso       (miso),
    .mosi       (mosi),
    .sclk       (sclk)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer. The slave drives s MSB first (or echoes mosi when loop=1).
  // go_mode=1: go held high 100 cycles with a second rising edge during busy.
  // chg=1: datai/CPOL/clk_divider altered mid-transfer. abort_e>0: reset at that sclk edge.
  task automatic xfer(input string name, input bit cpol, input bit cpha, input int div,
                      input logic [DW-1:0] d, input logic [DW-1:0] s, input bit loop,
                      input int go_mode, input bit chg, input int abort_e);
    int h, exp_busy, min_cyc, busy_cnt, done_cnt, done_at, edges, rises;
    int first_edge, last_edge_at, iv, min_iv, max_iv, bad_mosi, lead, trail, idx;
    bit prev_busy, prev_sclk, prev_mosi, seen_busy, finished, aborted;
    bit sclk_first, new_cpol, edge_now, sample;
    logic [DW-1:0] tx_seen, exp_rx;
    h = div + 1;
    exp_busy = (2 * DW + 1) * h + 1;
    min_cyc = (go_mode == 1) ? 100 : 0;
    busy_cnt = 0; done_cnt = 0; done_at = 0; edges = 0; rises = 0;
    first_edge = 0; last_edge_at = 0; min_iv = 1 << 30; max_iv = 0;
    bad_mosi = 0; lead = 0; trail = 0;
    seen_busy = 0; finished = 0; aborted = 0; sclk_first = ~cpol;
    new_cpol = cpol; tx_seen = '0;
    exp_rx = loop ? d : s;

    @(negedge clk);
    CPOL = cpol; CPHA = cpha; clk_divider = CW'(div); datai = d; go = 1'b0;
    miso = loop ? 1'b0 : s[DW-1];
    repeat (3) @(negedge clk);
    chk({name, " idle_sclk"}, 32'(sclk), 32'(cpol));
    prev_busy = busy; prev_sclk = sclk; prev_mosi = mosi;
    go = 1'b1;

    for (int cyc = 1; cyc <= 20000 && !finished; cyc++) begin
      @(negedge clk);
      if (busy && !prev_busy) rises++;
      if (busy) begin
        busy_cnt++;
        seen_busy = 1;
        if (busy_cnt == 1) sclk_first = sclk;
      end
      if (done) begin
        done_cnt++;
        done_at = busy_cnt;
      end
      edge_now = prev_busy && busy && (sclk != prev_sclk);
      sample = 0;
      if (edge_now) begin
        edges++;
        if (edges == 1) first_edge = busy_cnt;
        else begin
          iv = busy_cnt - last_edge_at;
          if (iv < min_iv) min_iv = iv;
          if (iv > max_iv) max_iv = iv;
        end
        last_edge_at = busy_cnt;
        if (edges % 2 == 1) lead++; else trail++;
        sample = cpha ? (edges % 2 == 0) : (edges % 2 == 1);
        if (sample) tx_seen = {tx_seen[DW-2:0], prev_mosi};
      end
      // mosi may only move on the mode's shift edge while a transfer is running
      if (prev_busy && busy && (mosi != prev_mosi) && !(edge_now && !sample)) bad_mosi++;
      if (abort_e != 0 && edges == abort_e) begin
        aborted = 1;
        finished = 1;
      end
      if (loop) miso = mosi;
      else begin
        idx = cpha ? ((lead == 0) ? 0 : lead - 1) : trail;
        miso = (idx < DW) ? s[DW-1-idx] : 1'b0;
      end
      if (go_mode == 1 && busy) begin
        if (busy_cnt == 10) go = 1'b0;
        if (busy_cnt == 12) go = 1'b1;
      end
      if (chg && busy && busy_cnt == 5) begin
        new_cpol = ~cpol;
        CPOL = new_cpol;
        clk_divider = CW'(div + 3);
        datai = ~d;
      end
      if (seen_busy && !busy && cyc >= min_cyc) finished = 1;
      prev_busy = busy; prev_sclk = sclk; prev_mosi = mosi;
    end
    chk({name, " completed"}, 32'(finished), 32'd1);

    if (abort_e != 0) begin
      chk({name, " reached_abort_edge"}, 32'(aborted), 32'd1);
      reset = 1'b1;
      #1;
      chk({name, " abort_sclk"}, 32'(sclk), 32'd0);
      chk({name, " abort_mosi"}, 32'(mosi), 32'd0);
      chk({name, " abort_busy"}, 32'(busy), 32'd0);
      chk({name, " abort_done"}, 32'(done), 32'd0);
      chk({name, " abort_datao"}, 32'(datao), 32'd0);
      go = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      reset = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      chk({name, " abort_no_done"}, 32'(done_cnt), 32'd0);
    end else begin
      chk({name, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
      chk({name, " transfers"}, 32'(rises), 32'd1);
      chk({name, " done_pulses"}, 32'(done_cnt), 32'd1);
      chk({name, " done_last_cycle"}, 32'(done_at), 32'(exp_busy));
      chk({name, " sclk_edges"}, 32'(edges), 32'(2 * DW));
      chk({name, " first_edge"}, 32'(first_edge), 32'(2 * h + 1));
      chk({name, " half_min"}, 32'(min_iv), 32'(h));
      chk({name, " half_max"}, 32'(max_iv), 32'(h));
      chk({name, " sclk_start"}, 32'(sclk_first), 32'(cpol));
      chk({name, " mosi_bits"}, 32'(tx_seen), 32'(d));
      chk({name, " mosi_edges"}, 32'(bad_mosi), 32'd0);
      chk({name, " datao"}, 32'(datao), 32'(exp_rx));
      go = 1'b0;
      repeat (2) @(negedge clk);
      chk({name, " idle_after"}, 32'(sclk), 32'(new_cpol));
      chk({name, " busy_after"}, 32'(busy), 32'd0);
    end
    $display("xfer %s cpol=%0d cpha=%0d div=%0d tx=%02h slave=%02h datao=%02h busy=%0d done=%0d",
             name, cpol, cpha, div, d, s, datao, busy_cnt, done_cnt);
  endtask

  initial begin
    int m, dv;
    logic [DW-1:0] rd, rs;
    reset = 1'b1; CPOL = 1'b0; CPHA = 1'b0; go = 1'b0; miso = 1'b0;
    clk_divider = '0; datai = '0;
    repeat (3) @(negedge clk);
    chk("reset sclk", 32'(sclk), 32'd0);
    chk("reset mosi", 32'(mosi), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset datao", 32'(datao), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    xfer("mode0_loop", 1'b0, 1'b0, 0, 8'hA5, 8'h00, 1'b1, 0, 1'b0, 0);
    xfer("mode3", 1'b1, 1'b1, 3, 8'h3C, 8'hC3, 1'b0, 0, 1'b0, 0);
    xfer("mode1", 1'b0, 1'b1, 1, 8'h81, 8'h7E, 1'b0, 0, 1'b0, 0);
    xfer("mode2", 1'b1, 1'b0, 2, 8'h81, 8'h7E, 1'b0, 0, 1'b0, 0);
    xfer("go_held", 1'b0, 1'b0, 0, 8'h5A, 8'h96, 1'b0, 1, 1'b0, 0);
    xfer("go_again", 1'b0, 1'b0, 0, 8'h69, 8'hE1, 1'b0, 0, 1'b0, 0);
    xfer("mid_change", 1'b1, 1'b0, 2, 8'h6B, 8'h1D, 1'b0, 0, 1'b1, 0);
    xfer("abort", 1'b0, 1'b0, 1, 8'hF0, 8'h55, 1'b0, 0, 1'b0, 7);
    xfer("post_abort", 1'b0, 1'b0, 1, 8'hC6, 8'h2B, 1'b0, 0, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      m  = int'($urandom_range(0, 3));
      dv = int'($urandom_range(0, 4));
      rd = DW'($urandom);
      rs = DW'($urandom);
      xfer("random", m[1], m[0], dv, rd, rs, bit'($urandom_range(0, 1)), 0, 1'b0, 0);
    end
    xfer("max_div", 1'b1, 1'b1, (1 << CW) - 1, 8'h96, 8'h4D, 1'b0, 0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
